// File: rtl/pixel_timing_gen_if.sv
// Control and raster-status bundle between the pixel timing generator and its user.
// The slave side is the generator; the master side programs the ratio and consumes the raster.
interface pixel_timing_gen_if #(
   parameter int NUM_W = 8,
   parameter int CNT_W = 11
);
   logic             enable;
   logic [NUM_W-1:0] ratio_num;
   logic [NUM_W-1:0] ratio_den;
   logic             flag_pixel;
   logic [CNT_W-1:0] h_count;
   logic [CNT_W-1:0] v_count;
   logic             hsync;
   logic             vsync;
   logic             active_video;
   logic             line_end;
   logic             frame_start;
   logic             config_err;

   modport master (
      output enable, ratio_num, ratio_den,
      input  flag_pixel, h_count, v_count, hsync, vsync,
             active_video, line_end, frame_start, config_err
   );

   modport slave (
      input  enable, ratio_num, ratio_den,
      output flag_pixel, h_count, v_count, hsync, vsync,
             active_video, line_end, frame_start, config_err
   );
endinterface

// File: rtl/pixel_timing_gen.sv
// Fractional pixel strobe (phase accumulator) with horizontal/vertical raster counters
// and sync/active/line/frame decode, all on the fast clock.
module pixel_timing_gen #(
   parameter int NUM_W        = 8,
   parameter int CNT_W        = 11,
   parameter int H_ACTIVE     = 640,
   parameter int H_SYNC_START = 656,
   parameter int H_SYNC_END   = 752,
   parameter int H_TOTAL      = 800,
   parameter int V_ACTIVE     = 480,
   parameter int V_SYNC_START = 490,
   parameter int V_SYNC_END   = 492,
   parameter int V_TOTAL      = 525,
   parameter bit SYNC_POL     = 1'b0
) (
   input logic               clk,
   input logic               n_rst,
   pixel_timing_gen_if.slave bus
);

   localparam logic [CNT_W-1:0] H_ACT_C   = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] H_SS_C    = CNT_W'(H_SYNC_START);
   localparam logic [CNT_W-1:0] H_SE_C    = CNT_W'(H_SYNC_END);
   localparam logic [CNT_W-1:0] H_LAST_C  = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_ACT_C   = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] V_SS_C    = CNT_W'(V_SYNC_START);
   localparam logic [CNT_W-1:0] V_SE_C    = CNT_W'(V_SYNC_END);
   localparam logic [CNT_W-1:0] V_LAST_C  = CNT_W'(V_TOTAL - 1);

   logic [NUM_W-1:0] num_q;
   logic [NUM_W-1:0] den_q;
   logic [NUM_W:0]   acc;
   logic [NUM_W:0]   sum;
   logic             flag_q;
   logic [CNT_W-1:0] h_q;
   logic [CNT_W-1:0] v_q;
   logic             cfg_bad;
   logic             h_in_sync;
   logic             v_in_sync;

   // acc stays below den_q, so the extra bit is enough to hold acc + num_q
   assign sum     = acc + {1'b0, num_q};
   assign cfg_bad = (num_q == '0) || (num_q > den_q);

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         acc    <= '0;
         flag_q <= 1'b0;
         h_q    <= '0;
         v_q    <= '0;
         num_q  <= NUM_W'(1);
         den_q  <= NUM_W'(1);
      end else if (!bus.enable) begin
         acc    <= '0;
         flag_q <= 1'b0;
         h_q    <= '0;
         v_q    <= '0;
         num_q  <= bus.ratio_num;
         den_q  <= bus.ratio_den;
      end else if (cfg_bad) begin
         flag_q <= 1'b0;
      end else begin
         if (sum >= {1'b0, den_q}) begin
            acc    <= sum - {1'b0, den_q};
            flag_q <= 1'b1;
         end else begin
            acc    <= sum;
            flag_q <= 1'b0;
         end
         // The counters name the pixel currently strobed, so they step after the strobe
         if (flag_q) begin
            if (h_q == H_LAST_C) begin
               h_q <= '0;
               v_q <= (v_q == V_LAST_C) ? '0 : v_q + 1'b1;
            end else begin
               h_q <= h_q + 1'b1;
            end
         end
      end
   end

   assign h_in_sync = (h_q >= H_SS_C) && (h_q < H_SE_C);
   assign v_in_sync = (v_q >= V_SS_C) && (v_q < V_SE_C);

   assign bus.flag_pixel   = flag_q;
   assign bus.h_count      = h_q;
   assign bus.v_count      = v_q;
   assign bus.hsync        = h_in_sync ? SYNC_POL : ~SYNC_POL;
   assign bus.vsync        = v_in_sync ? SYNC_POL : ~SYNC_POL;
   assign bus.active_video = (h_q < H_ACT_C) && (v_q < V_ACT_C);
   assign bus.line_end     = flag_q && (h_q == H_LAST_C);
   assign bus.frame_start  = flag_q && (h_q == '0) && (v_q == '0);
   assign bus.config_err   = cfg_bad;

endmodule

// File: doc/pixel_timing_gen.md
Name: pixel_timing_gen

Overview:
- Successor to the fixed-ratio pixel strobe generator.
- Derives a pixel-rate strobe from the fast shift-register clock using a runtime-programmable fractional ratio (phase accumulator). For example, 3/5 gives 150 MHz pixel strobes from 250 MHz.
- Adds parametrised horizontal/vertical raster counters with sync, active-video, line-end and frame-start outputs for the display path.
- Single clock domain; all state advances on the fast clock.

Parameters:
NUM_W, 8, width of ratio_num / ratio_den and the accumulator (accumulator is NUM_W+1 bits)
CNT_W, 11, width of h_count / v_count
H_ACTIVE, 640, visible pixels per line
H_SYNC_START, 656, first h_count with hsync asserted
H_SYNC_END, 752, first h_count after hsync (exclusive)
H_TOTAL, 800, pixels per line
V_ACTIVE, 480, visible lines per frame
V_SYNC_START, 490, first v_count with vsync asserted
V_SYNC_END, 492, first v_count after vsync (exclusive)
V_TOTAL, 525, lines per frame
SYNC_POL, 0, sync polarity (0 = active-low, 1 = active-high)

Ports:
clk  in  1  fast clock, rising edge
n_rst  in  1  synchronous active-low reset
enable  in  1  1 = run; 0 = idle and reload ratio
ratio_num  in  NUM_W  strobes per ratio_den clocks
ratio_den  in  NUM_W  clock period of the ratio
flag_pixel  out  1  one-cycle pixel strobe (registered)
h_count  out  CNT_W  column of the current/next strobe
v_count  out  CNT_W  line of the current/next strobe
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
active_video  out  1  h_count < H_ACTIVE and v_count < V_ACTIVE
line_end  out  1  flag_pixel and h_count == H_TOTAL-1
frame_start  out  1  flag_pixel and h_count == 0 and v_count == 0
config_err  out  1  shadow ratio invalid

Behaviour:
- Reset (n_rst=0 at a rising edge; overrides everything):
  - acc=0, flag_pixel=0, h_count=0, v_count=0.
  - Shadow num_q=1, den_q=1.
  - Hence config_err=0, active_video=1, line_end=0, frame_start=0, hsync/vsync deasserted.
- Shadow registers:
  - While enable=0, num_q<=ratio_num and den_q<=ratio_den every cycle.
  - While enable=1 the shadows are frozen; input changes are ignored until the next enable=0 cycle.
- config_err = (num_q==0) or (num_q>den_q). It is combinational from the shadows.
  - While config_err=1, acc and counters hold and flag_pixel=0.
- enable=0 cycle: acc<=0, flag_pixel<=0, h_count<=0, v_count<=0.
  - Dropping enable mid-frame therefore restarts the raster at (0,0).
- enable=1, config_err=0, per cycle:
  - sum = acc + num_q, computed in NUM_W+1 bits (no overflow since acc < den_q).
  - If sum >= den_q: acc<=sum-den_q and flag_pixel<=1. Otherwise acc<=sum and flag_pixel<=0.
  - Over any den_q consecutive cycles, exactly num_q strobes occur. num_q==den_q gives a strobe every cycle.
- Counter timing:
  - The counters identify the pixel being strobed.
  - At each edge where flag_pixel==1 (and enable=1, reset inactive), the counters advance after that strobe.
  - h_count wraps from H_TOTAL-1 to 0 and increments v_count.
  - v_count wraps from V_TOTAL-1 to 0 on the same edge.
  - The first strobe after enable therefore reports (0,0).
- Decode (combinational from counters):
  - hsync = SYNC_POL when H_SYNC_START <= h_count < H_SYNC_END, else ~SYNC_POL.
  - vsync: same rule using v_count and the V_SYNC bounds.
- Simultaneous events: reset beats enable; enable=0 beats a pending advance; line and frame wrap occur on one edge.
- Latency: first flag_pixel appears ceil(den_q/num_q) cycles after enable rises (registered output).

Test Plan:
- Reset, then enable=0 with ratio 3/5, then enable=1 -> flag_pixel pattern 0,1,0,1,1 repeating; exactly 3 strobes per 5 clocks over 100 clocks.
- Ratio 1/1 -> flag_pixel high every cycle from the first edge after enable; ratio 1/4 -> one strobe every 4th cycle.
- H_ACTIVE=4, H_SYNC 4..5, H_TOTAL=6, V_ACTIVE=2, V_SYNC 2..3, V_TOTAL=3, ratio 1/1:
  - h_count cycles 0..5 and line_end fires at h=5.
  - hsync is low only at h=4 (SYNC_POL=0).
  - vsync is low on line 2.
  - frame_start fires every 18 strobes.
  - active_video is high for 8 pixels per frame.
- Change ratio_num while enable=1 -> no effect on strobe rate; after an enable=0 cycle the new ratio takes effect.
- ratio 0/5 or 6/5 loaded -> config_err=1, no strobes, counters frozen; loading 2/5 clears config_err.
- Drop n_rst and separately enable mid-line at (3,1) -> next cycle acc=0, counters (0,0), flag_pixel=0; reset also restores the 1/1 shadow.
